// File: rtl/eth_tx_nibbler.sv
// ============================================================================
// eth_tx_nibbler : MII transmit framer, byte stream in, one nibble per DIV clocks out
// Optional FCS append when ETH_TX_FCS_EN is defined.  Revision: 1.0
// ============================================================================
`default_nettype none

module eth_tx_nibbler #(
  parameter int DIV         = 5,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       rx_clk125,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       slot,
  output logic       underrun,
  output logic       busy
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) : 4;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [IW-1:0] PRE_LAST = IW'(15);
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_NIBBLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_IFG  = 3'd4;
`ifdef ETH_TX_FCS_EN
  localparam logic [2:0]  S_FCS    = 3'd3;
  localparam logic [IW-1:0] FCS_LAST = IW'(7);
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          hi_q, hi_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic [3:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          underrun_q, underrun_d;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_w;

  // Reflected CRC-32, one byte per call, LSB of the byte first
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_w = ~crc_q;
`endif

  assign slot     = (cnt_q == CNT_MAX);
  assign in_ready = slot & (state_q == S_DATA) & ~hi_q;
  assign busy     = (state_q != S_IDLE);
  assign txd      = txd_q;
  assign tx_en    = tx_en_q;
  assign underrun = underrun_q;

  always_comb begin
    cnt_d      = slot ? '0 : cnt_q + 1'b1;
    state_d    = state_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    byte_d     = byte_q;
    last_d     = last_q;
    txd_d      = txd_q;
    tx_en_d    = tx_en_q;
    underrun_d = 1'b0;
`ifdef ETH_TX_FCS_EN
    crc_d      = crc_q;
`endif

    if (slot) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_PRE;
            tx_en_d = 1'b1;
            txd_d   = 4'h5;
            idx_d   = IW'(1);
`ifdef ETH_TX_FCS_EN
            crc_d   = 32'hFFFFFFFF;
`endif
          end else begin
            tx_en_d = 1'b0;
            txd_d   = 4'h0;
          end
        end

        S_PRE: begin
          if (idx_q == PRE_LAST) begin
            txd_d   = 4'hD;
            state_d = S_DATA;
            hi_d    = 1'b0;
          end else begin
            txd_d = 4'h5;
            idx_d = idx_q + 1'b1;
          end
        end

        S_DATA: begin
          if (!hi_q) begin
            if (in_valid) begin
              byte_d = in_data;
              last_d = in_last;
              txd_d  = in_data[3:0];
              hi_d   = 1'b1;
`ifdef ETH_TX_FCS_EN
              crc_d  = crc32_byte(crc_q, in_data);
`endif
            end else begin
              // Starved at a low-nibble slot: drop tx_en and fall into the gap
              tx_en_d    = 1'b0;
              txd_d      = 4'h0;
              underrun_d = 1'b1;
              state_d    = S_IFG;
              idx_d      = '0;
`ifdef ETH_TX_FCS_EN
              crc_d      = 32'hFFFFFFFF;
`endif
            end
          end else begin
            txd_d = byte_q[7:4];
            hi_d  = 1'b0;
            if (last_q) begin
              idx_d = '0;
`ifdef ETH_TX_FCS_EN
              state_d = S_FCS;
`else
              state_d = S_IFG;
`endif
            end
          end
        end

`ifdef ETH_TX_FCS_EN
        S_FCS: begin
          txd_d = fcs_w[{idx_q[2:0], 2'b00} +: 4];
          if (idx_q == FCS_LAST) begin
            state_d = S_IFG;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
`endif

        S_IFG: begin
          tx_en_d = 1'b0;
          txd_d   = 4'h0;
          if (idx_q == IFG_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          tx_en_d = 1'b0;
          txd_d   = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk125 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hi_q       <= 1'b0;
      byte_q     <= 8'h00;
      last_q     <= 1'b0;
      txd_q      <= 4'h0;
      tx_en_q    <= 1'b0;
      underrun_q <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc_q      <= 32'hFFFFFFFF;
`endif
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      underrun_q <= underrun_d;
`ifdef ETH_TX_FCS_EN
      crc_q      <= crc_d;
`endif
    end
  end

endmodule

`default_nettype wire
